// File: rtl/seq_signed_divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Optional build macro DIV_SATURATE_EN is consumed by the top module.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } div_state_t;

   localparam int DIV_WIDTH   = 4;
   localparam int DIV_LATENCY = DIV_WIDTH + 2;

   // Magnitude of a sign-extended operand, one bit wider so the most
   // negative value stays representable.
   function automatic logic [32:0] div_abs(input logic signed [31:0] v);
      logic signed [32:0] w;
      w = {v[31], v};
      return w[32] ? 33'(-w) : 33'(w);
   endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/busy/done handshake bundle for the sequential signed divider.
// The requester uses master, the divider uses slave.
interface seq_signed_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic                    start;
   logic signed [WIDTH-1:0] dividend;
   logic signed [WIDTH-1:0] divisor;
   logic                    busy;
   logic                    done;
   logic signed [WIDTH-1:0] quotient;
   logic signed [WIDTH-1:0] remainder;
   logic                    div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_signed_divider_restore_step.sv
// One combinational restoring-division iteration on magnitudes.
// Reused by the divider once per CALC cycle.
module div_restore_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0] i_rem,
   input  logic           i_bit,
   input  logic [WIDTH:0] i_dvs,
   output logic [WIDTH:0] o_rem,
   output logic           o_q
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {1'b0, i_dvs};
   assign o_q     = ~w_diff[WIDTH+1];
   assign o_rem   = o_q ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider: IDLE -> CALC (WIDTH cycles) -> FIX.
// Define DIV_SATURATE_EN to saturate overflow and divide-by-zero quotients.
module seq_signed_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input logic                 clk,
   input logic                 rst,
   seq_signed_divider_if.slave bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   div_state_t       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dq;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH:0]   r_dvs;
   logic [WIDTH-1:0] r_dvd;
   logic             r_zero;
   logic             r_ovf;
   logic             r_sgn_q;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rmd;
   logic             r_dbz;

   logic [WIDTH-1:0] w_dvd_abs;
   logic [WIDTH:0]   w_dvs_abs;
   logic [WIDTH-1:0] w_min;
   logic             w_ovf;
   logic [WIDTH:0]   w_rem_nxt;
   logic             w_q_bit;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   assign w_dvd_abs = WIDTH'(div_abs(32'(signed'(bus.dividend))));
   assign w_dvs_abs = (WIDTH+1)'(div_abs(32'(signed'(bus.divisor))));
   assign w_min     = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_ovf     = (bus.dividend == w_min) && (bus.divisor == '1);

   // Dividend bits leave r_dq at the top while quotient bits enter below.
   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem (r_rem),
      .i_bit (r_dq[WIDTH-1]),
      .i_dvs (r_dvs),
      .o_rem (w_rem_nxt),
      .o_q   (w_q_bit)
   );

`ifdef DIV_SATURATE_EN
   logic [WIDTH-1:0] w_max;
   assign w_max = ~w_min;
`endif

   always_comb begin
      w_q_fix = r_sgn_q ? -r_dq : r_dq;
      w_r_fix = r_dvd[WIDTH-1] ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
      if (r_zero) begin
`ifdef DIV_SATURATE_EN
         w_q_fix = r_dvd[WIDTH-1] ? w_min : w_max;
`else
         w_q_fix = '1;
`endif
         w_r_fix = r_dvd;
      end else if (r_ovf) begin
`ifdef DIV_SATURATE_EN
         w_q_fix = w_max;
`else
         w_q_fix = w_min;
`endif
         w_r_fix = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_dq    <= '0;
         r_rem   <= '0;
         r_dvs   <= '0;
         r_dvd   <= '0;
         r_zero  <= 1'b0;
         r_ovf   <= 1'b0;
         r_sgn_q <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_quo   <= '0;
         r_rmd   <= '0;
         r_dbz   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_dq    <= w_dvd_abs;
                  r_dvs   <= w_dvs_abs;
                  r_dvd   <= bus.dividend;
                  r_sgn_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  r_zero  <= (bus.divisor == '0);
                  r_ovf   <= w_ovf;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_dq  <= {r_dq[WIDTH-2:0], w_q_bit};
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
            end
            FIX: begin
               r_quo   <= w_q_fix;
               r_rmd   <= w_r_fix;
               r_dbz   <= r_zero;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quo;
   assign bus.remainder   = r_rmd;
   assign bus.div_by_zero = r_dbz;

endmodule
